// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// Memory size falls back to 4 KiB when the build does not define DATA_MEMSIZE.
`ifndef DATA_MEMSIZE
`define DATA_MEMSIZE 4096
`endif

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  typedef logic port_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    size_e       size;
    logic        uns;
    logic        lock;
  } req_t;

  function automatic logic [2:0] size_bytes(size_e s);
    case (s)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic is_aligned(size_e s, logic [1:0] a);
    case (s)
      SZ_B:    return 1'b1;
      SZ_H:    return ~a[0];
      SZ_W:    return a == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-input picker: round-robin on a tie (or port 0 always with FIXED_PRIO),
// restricted to the ports enabled by mask.
module dmem_rr_pick
  import dmem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_t      prio;  // port that wins the next tie
  logic [1:0] elig;

  always_comb begin
    elig = req & mask;
    if (elig == 2'b11) gnt = (FIXED_PRIO || prio == 1'b0) ? 2'b01 : 2'b10;
    else               gnt = elig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      prio <= 1'b0;
    else if (advance && gnt != 2'b00) prio <= gnt[0];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port byte-addressed data memory between the LSU (port 0)
// and the DMA/debug engine (port 1), with access checking and a bus lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = `DATA_MEMSIZE,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_0,
  input  logic        req_1,
  input  logic        we_0,
  input  logic        we_1,
  input  logic [31:0] addr_0,
  input  logic [31:0] addr_1,
  input  logic [31:0] wdata_0,
  input  logic [31:0] wdata_1,
  input  logic [1:0]  size_0,
  input  logic [1:0]  size_1,
  input  logic        uns_0,
  input  logic        uns_1,
  input  logic        lock_0,
  input  logic        lock_1,
  output logic        gnt_0,
  output logic        gnt_1,
  output logic        rvalid_0,
  output logic        rvalid_1,
  output logic [31:0] rdata_0,
  output logic [31:0] rdata_1,
  output logic        err_0,
  output logic        err_1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_store,
  output logic        mem_load,
  output logic [2:0]  mem_size,
  input  logic [31:0] mem_rdata
);

  req_t [1:0] rq;
  logic [1:0] req, mask, gnt;
  logic       lock_vld, rel_now, any, win_ok;
  port_t      lock_own, win;
  req_t       wr;

  logic [31:0] addr_q, wdata_q, ext;
  logic [2:0]  size_q;
  logic [1:0]  rsp_vld;
  logic        rsp_err, rsp_load, rsp_uns;
  size_e       rsp_size;

  function automatic logic legal_acc(req_t r);
    logic [32:0] end_addr;
    end_addr = {1'b0, r.addr} + 33'(size_bytes(r.size));
    return (r.size != SZ_BAD) && is_aligned(r.size, r.addr[1:0]) &&
           (end_addr <= 33'(MEM_BYTES));
  endfunction

  assign rq[0] = {we_0, addr_0, wdata_0, size_e'(size_0), uns_0, lock_0};
  assign rq[1] = {we_1, addr_1, wdata_1, size_e'(size_1), uns_1, lock_1};
  assign req   = {req_1, req_0} & {2{rst_n}};

  // An owner dropping req and lock together frees the bus in the same cycle.
  assign rel_now = lock_vld && !req[lock_own] && !rq[lock_own].lock;
  assign mask    = (lock_vld && !rel_now) ? (lock_own ? 2'b10 : 2'b01) : 2'b11;

  dmem_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mask    (mask),
    .advance (any),
    .gnt     (gnt)
  );

  assign gnt_0  = gnt[0];
  assign gnt_1  = gnt[1];
  assign any    = |gnt;
  assign win    = gnt[1];
  assign wr     = rq[win];
  assign win_ok = legal_acc(wr);

  assign mem_store = any & win_ok & wr.we;
  assign mem_load  = any & win_ok & ~wr.we;
  assign mem_addr  = any ? wr.addr : addr_q;
  assign mem_wdata = any ? wr.wdata : wdata_q;
  assign mem_size  = any ? size_bytes(wr.size) : size_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld <= 1'b0;
      lock_own <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      rsp_vld  <= '0;
      rsp_err  <= 1'b0;
      rsp_load <= 1'b0;
      rsp_uns  <= 1'b0;
      rsp_size <= SZ_B;
    end else begin
      rsp_vld  <= gnt;
      rsp_err  <= any & ~win_ok;
      rsp_load <= any & win_ok & ~wr.we;
      if (any) begin
        addr_q   <= wr.addr;
        wdata_q  <= wr.wdata;
        size_q   <= size_bytes(wr.size);
        rsp_size <= wr.size;
        rsp_uns  <= wr.uns;
      end
      if (rel_now) lock_vld <= 1'b0;
      // Rejected accesses leave ownership untouched.
      if (any && win_ok) begin
        if (wr.lock) begin
          lock_vld <= 1'b1;
          lock_own <= win;
        end else if (lock_vld && lock_own == win) begin
          lock_vld <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    case (rsp_size)
      SZ_B:    ext = rsp_uns ? {24'b0, mem_rdata[7:0]}  : {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      SZ_H:    ext = rsp_uns ? {16'b0, mem_rdata[15:0]} : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      default: ext = mem_rdata;
    endcase
    if (!rsp_load) ext = '0;
  end

  assign rvalid_0 = rsp_vld[0];
  assign rvalid_1 = rsp_vld[1];
  assign err_0    = rsp_vld[0] & rsp_err;
  assign err_1    = rsp_vld[1] & rsp_err;
  assign rdata_0  = rsp_vld[0] ? ext : '0;
  assign rdata_1  = rsp_vld[1] ? ext : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: every accepted grant queues its expected response and a
// negedge monitor checks each rvalid pulse against the queue in order.
module tb_dmem_arbiter;

  localparam int MB = 256;

  typedef struct {
    int          p;
    logic        e;
    logic [31:0] d;
  } exp_t;

  logic clk, rst_n;
  logic [1:0]       req, we, uns, lock;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][1:0]  size;

  logic        gnt_0, gnt_1, rvalid_0, rvalid_1, err_0, err_1, mem_store, mem_load;
  logic [31:0] rdata_0, rdata_1, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_size;

  logic        gnt_f0, gnt_f1, rvalid_f0, rvalid_f1, err_f0, err_f1, store_f, load_f;
  logic [31:0] rdata_f0, rdata_f1, addr_f, wdata_f;
  logic [2:0]  size_f;

  logic [7:0] mem [MB];
  exp_t       q[$];
  int         checks = 0, errors = 0, rv_seen = 0;

  dmem_arbiter #(.MEM_BYTES(MB), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req[0]), .req_1(req[1]), .we_0(we[0]), .we_1(we[1]),
    .addr_0(addr[0]), .addr_1(addr[1]), .wdata_0(wdata[0]), .wdata_1(wdata[1]),
    .size_0(size[0]), .size_1(size[1]), .uns_0(uns[0]), .uns_1(uns[1]),
    .lock_0(lock[0]), .lock_1(lock[1]),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1), .err_0(err_0), .err_1(err_1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_store(mem_store),
    .mem_load(mem_load), .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.MEM_BYTES(MB), .FIXED_PRIO(1'b1)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .req_0(req[0]), .req_1(req[1]), .we_0(we[0]), .we_1(we[1]),
    .addr_0(addr[0]), .addr_1(addr[1]), .wdata_0(wdata[0]), .wdata_1(wdata[1]),
    .size_0(size[0]), .size_1(size[1]), .uns_0(uns[0]), .uns_1(uns[1]),
    .lock_0(lock[0]), .lock_1(lock[1]),
    .gnt_0(gnt_f0), .gnt_1(gnt_f1), .rvalid_0(rvalid_f0), .rvalid_1(rvalid_f1),
    .rdata_0(rdata_f0), .rdata_1(rdata_f1), .err_0(err_f0), .err_1(err_f1),
    .mem_addr(addr_f), .mem_wdata(wdata_f), .mem_store(store_f),
    .mem_load(load_f), .mem_size(size_f), .mem_rdata(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mrd(logic [31:0] a, logic [2:0] n);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(n)) r[8*i +: 8] = mem[8'(a + 32'(i))];
    return r;
  endfunction

  // Memory model: registered read data, sized little-endian stores.
  always @(posedge clk) begin
    if (mem_store)
      for (int i = 0; i < 4; i++)
        if (i < int'(mem_size)) mem[8'(mem_addr + 32'(i))] <= mem_wdata[8*i +: 8];
    if (mem_load) mem_rdata <= mrd(mem_addr, mem_size);
  end

  always @(negedge clk) begin
    exp_t x;
    logic [1:0]       rv;
    logic [1:0]       er;
    logic [1:0][31:0] rd;
    rv = {rvalid_1, rvalid_0};
    er = {err_1, err_0};
    rd = {rdata_1, rdata_0};
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (rv[p]) begin
          rv_seen++;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid port %0d err %0b rdata %h", p, er[p], rd[p]);
          end else begin
            x = q.pop_front();
            if (x.p != p || x.e != er[p] || x.d != rd[p]) begin
              errors++;
              $display("FAIL rsp got port %0d err %0b rdata %h, need port %0d err %0b rdata %h",
                       p, er[p], rd[p], x.p, x.e, x.d);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s got %h need %h", nm, act, req_v);
    end
  endtask

  task automatic set_port(input int p, input logic w, input logic [31:0] a, d,
                          input logic [1:0] sz, input logic u, input logic lk);
    we[p] = w; addr[p] = a; wdata[p] = d; size[p] = sz; uns[p] = u; lock[p] = lk;
  endtask

  task automatic acc(input int p, input logic w, input logic [31:0] a, d,
                     input logic [1:0] sz, input logic u, input logic e, input logic [31:0] x);
    logic got;
    got = 1'b0;
    set_port(p, w, a, d, sz, u, 1'b0);
    req[p] = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? gnt_0 : gnt_1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL gnt_timeout port %0d addr %h", p, a);
    end else begin
      q.push_back('{p, e, x});
      chk("mem_store", 32'(mem_store), 32'(!e && w));
      chk("mem_load", 32'(mem_load), 32'(!e && !w));
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  initial begin
    int seen0;
    for (int i = 0; i < MB; i++) mem[i] = 8'h00;
    mem_rdata = '0;
    req = '0; we = '0; uns = '0; lock = '0; addr = '0; wdata = '0; size = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'({rvalid_1, rvalid_0}), 32'h0);
    chk("rst_err", 32'({err_1, err_0}), 32'h0);
    chk("rst_mem_ctl", 32'({mem_store, mem_load}), 32'h0);
    chk("rst_rdata", rdata_0 | rdata_1, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // port, we, addr, wdata, size, uns, exp err, exp rdata
    acc(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, 32'h0);
    acc(0, 0, 32'h10, 32'h0,        2'b10, 0, 0, 32'hDEADBEEF);
    acc(0, 0, 32'h10, 32'h0,        2'b00, 0, 0, 32'hFFFFFFEF);
    acc(0, 0, 32'h10, 32'h0,        2'b00, 1, 0, 32'h000000EF);
    acc(0, 0, 32'h10, 32'h0,        2'b01, 0, 0, 32'hFFFFBEEF);
    acc(0, 0, 32'h12, 32'h0,        2'b01, 1, 0, 32'h0000DEAD);
    acc(1, 1, 32'h11, 32'h00001234, 2'b01, 0, 1, 32'h0);
    acc(1, 0, 32'h10, 32'h0,        2'b10, 0, 0, 32'hDEADBEEF);
    acc(0, 0, 32'h10, 32'h0,        2'b11, 0, 1, 32'h0);
    acc(0, 0, MB - 2, 32'h0,        2'b10, 0, 1, 32'h0);
    acc(0, 1, MB - 4, 32'hCAFEF00D, 2'b10, 0, 0, 32'h0);
    acc(1, 0, MB - 4, 32'h0,        2'b10, 0, 0, 32'hCAFEF00D);

    // Contention: last single grant was port 1, so round-robin starts at port 0.
    set_port(0, 0, 32'h10, 0, 2'b10, 0, 0);
    set_port(1, 0, 32'h10, 0, 2'b10, 0, 0);
    req = 2'b11;
    for (int c = 0; c < 4; c++) begin
      logic [1:0] g;
      g = (c % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      chk("rr_gnt", 32'({gnt_1, gnt_0}), 32'(g));
      chk("fixed_gnt", 32'({gnt_f1, gnt_f0}), 32'h1);
      q.push_back('{int'(g[1]), 1'b0, 32'hDEADBEEF});
      @(posedge clk); #1;
    end
    req = 2'b00;
    @(posedge clk); #1;

    // Lock: port 1 owns the bus across three grants while port 0 waits.
    set_port(1, 0, 32'h10, 0, 2'b10, 0, 1);
    req[1] = 1'b1;
    @(negedge clk);
    chk("lock_g1", 32'({gnt_1, gnt_0}), 32'h2);
    q.push_back('{1, 1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    set_port(0, 0, 32'h10, 0, 2'b00, 1, 0);
    req[0] = 1'b1;
    @(negedge clk);
    chk("lock_g2", 32'({gnt_1, gnt_0}), 32'h2);
    q.push_back('{1, 1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    lock[1] = 1'b0;
    @(negedge clk);
    chk("lock_g3", 32'({gnt_1, gnt_0}), 32'h2);
    q.push_back('{1, 1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    req[1] = 1'b0;
    lock[0] = 1'b1;
    @(negedge clk);
    chk("after_release", 32'({gnt_1, gnt_0}), 32'h1);
    q.push_back('{0, 1'b0, 32'h000000EF});
    @(posedge clk); #1;
    // Port 0 now owns; dropping req and lock together frees the bus at once.
    req[0] = 1'b0; lock[0] = 1'b0;
    req[1] = 1'b1;
    @(negedge clk);
    chk("immediate_release", 32'({gnt_1, gnt_0}), 32'h2);
    q.push_back('{1, 1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset the cycle after a load grant: the response must vanish.
    chk("queue_drained", 32'(q.size()), 32'h0);
    set_port(0, 0, 32'h10, 0, 2'b10, 0, 0);
    req[0] = 1'b1;
    @(negedge clk);
    chk("pre_rst_gnt", 32'({gnt_1, gnt_0}), 32'h1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst_n = 1'b0;
    seen0 = rv_seen;
    @(negedge clk);
    chk("rst_kill_rvalid", 32'({rvalid_1, rvalid_0}), 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_rvalid_after_rst", 32'(rv_seen - seen0), 32'h0);
    set_port(1, 0, 32'h10, 0, 2'b10, 0, 0);
    req = 2'b11;
    @(negedge clk);
    chk("rst_ptr_gnt", 32'({gnt_1, gnt_0}), 32'h1);
    q.push_back('{0, 1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between two requesters: port 0 is the core load/store unit and port 1 is the DMA/debug engine.
- Arbitrates every cycle and drives the memory's address, write-data, store, load and size inputs.
- Captures the memory's registered read data one cycle later, sign-extends it when required, and returns it to the winning requester.
- Rejects misaligned, out-of-range or illegal-size accesses without touching memory.
- Supports a lock so one requester can complete a read-modify-write sequence without interruption.

Parameters:
- MEM_BYTES, `DATA_MEMSIZE: memory size in bytes; an access with addr + bytes > MEM_BYTES is out of range.
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_0, req_1  in  1  access request, held until granted
- we_0, we_1  in  1  1 = store, 0 = load
- addr_0, addr_1  in  32  byte address
- wdata_0, wdata_1  in  32  store data, LSB-aligned
- size_0, size_1  in  2  00 byte, 01 half, 10 word, 11 illegal
- uns_0, uns_1  in  1  1 = zero-extend load data, 0 = sign-extend
- lock_0, lock_1  in  1  keep ownership after this grant
- gnt_0, gnt_1  out  1  combinational; request accepted this cycle
- rvalid_0, rvalid_1  out  1  response pulse, one cycle after the grant
- rdata_0, rdata_1  out  32  load data, valid only with rvalid
- err_0, err_1  out  1  access rejected, valid only with rvalid
- mem_addr  out  32  to memory result input
- mem_wdata  out  32  to memory data input
- mem_store  out  1  to memory store_mem input
- mem_load  out  1  to memory load_mem input
- mem_size  out  3  byte count: 1, 2 or 4
- mem_rdata  in  32  from memory out_data

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - rvalid_*, err_*, mem_store and mem_load are 0; rdata_* = 0.
  - Round-robin pointer favours port 0; lock owner cleared.
  - A response in flight is discarded and is never delivered after reset releases.
- Arbitration (cycle N, combinational):
  - Only one gnt is high at a time.
  - If a lock owner exists, only that port can be granted; the other port waits even while the owner idles.
  - Otherwise, with FIXED_PRIO=0 and both ports requesting, the port not granted most recently wins. The pointer updates only on a grant.
  - A single requester always wins.
- Legality of the granted access:
  - Legal means size != 11, the address is aligned (half: addr[0]=0; word: addr[1:0]=0), and it is in range.
  - Legal: mem_load = ~we or mem_store = we for that cycle. mem_addr, mem_wdata and mem_size come from the winner.
  - Illegal: mem_store = mem_load = 0; the request is still granted, then errored.
  - No grant: mem_store = mem_load = 0; mem_addr and mem_wdata hold their last value.
- Response (cycle N+1):
  - Registered: rvalid is high on the granted port for exactly one cycle.
  - err = 1 for an illegal access; otherwise 0.
  - Loads: rdata = mem_rdata, extended from the size bit 7 or 15 unless uns is set.
  - Stores and errors: rdata = 0.
- Pipelining: a new grant is allowed in cycle N+1, giving one access per cycle sustained.
- Lock:
  - A grant with lock set makes that port the owner.
  - The owner's next grant with lock clear releases ownership after that grant.
  - An owner deasserting req and lock together releases ownership immediately.
- Errored accesses never modify memory and never update lock ownership.

Decomposition:
- Shared package dmem_arb_pkg:
  - size_e {SZ_B, SZ_H, SZ_W, SZ_BAD}
  - port id type
  - size-to-bytes function
  - alignment-check function
- Sub-module dmem_rr_pick: two-input round-robin/fixed-priority picker holding the pointer register, with inputs req[1:0], mask[1:0] and advance, and output onehot gnt[1:0].

Test Plan:
- Store then load: port 0 stores word 0xDEADBEEF at 0x10, then loads a word from 0x10 → rvalid_0 at N+1 with err=0, then rdata_0 = 0xDEADBEEF.
- Sign extension: load byte 0xEF with uns=0 → 0xFFFFFFEF; with uns=1 → 0x000000EF. Load half at 0x10 with uns=0 → 0xFFFFBEEF.
- Contention: req_0 and req_1 held high for 4 cycles → grants alternate 0,1,0,1 with FIXED_PRIO=0; grants are 0,0,0,0 with FIXED_PRIO=1.
- Lock: port 1 holds lock for 3 grants while req_0 stays high → gnt_0 = 0 throughout, then port 0 is granted the cycle after release.
- Illegal accesses:
  - Half store at 0x11 → mem_store = 0, err_1 = 1 at N+1, memory unchanged (readback verifies).
  - size 11 → err = 1.
  - Word access at MEM_BYTES-2 → err = 1.
- Reset mid-operation: assert rst_n = 0 in the cycle after a load grant → no rvalid after release, and port 0 wins the first contended cycle.
